fanout_bcast_buffer: RTL and testbench

FANOUT_BCAST_BUFFER -- requirements
Module: fanout_bcast_buffer

---
 rtl/fanout_bcast_buffer.sv | 60 ++++++
 tb/tb_fanout_bcast_buffer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fanout_bcast_buffer.sv
// fanout_bcast_buffer: small FIFO whose head token is broadcast to every enabled consumer port,
// popping only after each enabled port has taken it exactly once.
module fanout_bcast_buffer #(
  parameter int NUM_OUT = 4,
  parameter int DW      = 17,
  parameter int DEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [NUM_OUT-1:0]         en_mask,
  input  logic [DW-1:0]              in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [NUM_OUT*DW-1:0]      out_data,
  output logic [NUM_OUT-1:0]         out_valid,
  input  logic [NUM_OUT-1:0]         out_ready,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [DW-1:0]      mem_q [DEPTH];
  logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic [NUM_OUT-1:0] sent_q, sent_d, xfer;
  logic               live_q, head, push, pop;
  // live_q keeps in_ready low until the first edge after reset release
  always_comb begin
    head      = cnt_q != '0;
    in_ready  = live_q & (cnt_q < FULL) & ~flush;
    out_valid = {NUM_OUT{head}} & en_mask & ~sent_q;
    xfer      = out_valid & out_ready;
    push      = in_valid & in_ready;
    pop       = head & (&(~en_mask | sent_q | xfer));
    wr_d      = flush ? '0 : wr_q + AW'(push);
    rd_d      = flush ? '0 : rd_q + AW'(pop);
    cnt_d     = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    sent_d    = (flush | pop) ? '0 : sent_q | xfer;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q <= 1'b0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      sent_q <= '0;
    end else begin
      live_q <= 1'b1;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      sent_q <= sent_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_data;
  end
  assign out_data  = {NUM_OUT{mem_q[rd_q]}};
  assign occupancy = cnt_q;
endmodule

// File: tb/tb_fanout_bcast_buffer.sv
// tb_fanout_bcast_buffer: table-driven directed vectors plus reset sequences for fanout_bcast_buffer.
module tb_fanout_bcast_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  en_mask = 4'h0;
  logic [16:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [67:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = 4'h0;
  logic [1:0]  occupancy;
  int n_chk = 0;
  int n_fail = 0;

  fanout_bcast_buffer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .en_mask(en_mask),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic [3:0]  en;
    logic [16:0] din;
    logic        iv;
    logic [3:0]  ord;
    logic        ir;
    logic [3:0]  ov;
    logic [1:0]  occ;
    logic [16:0] dat;
  } vec_t;
  vec_t v[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic ir, input logic [3:0] ov,
                         input logic [1:0] occ, input logic [16:0] dat);
    chk({nm, " in_ready"}, 32'(in_ready), 32'(ir));
    chk({nm, " out_valid"}, 32'(out_valid), 32'(ov));
    chk({nm, " occupancy"}, 32'(occupancy), 32'(occ));
    if (ov != 4'h0)
      for (int p = 0; p < 4; p++)
        chk($sformatf("%s data%0d", nm, p), 32'(out_data[p*17 +: 17]), 32'(dat));
  endtask

  initial begin
    // fl, en, din, iv, ord | ir, ov, occ, dat
    // back-to-back broadcast at full throughput
    v.push_back('{1'b0, 4'hF, 17'h00005, 1'b1, 4'hF, 1'b1, 4'h0, 2'd0, 17'h0});
    v.push_back('{1'b0, 4'hF, 17'h1FFFF, 1'b1, 4'hF, 1'b1, 4'hF, 2'd1, 17'h00005});
    v.push_back('{1'b0, 4'hF, 17'h00000, 1'b0, 4'hF, 1'b1, 4'hF, 2'd1, 17'h1FFFF});
    v.push_back('{1'b0, 4'hF, 17'h00000, 1'b0, 4'hF, 1'b1, 4'h0, 2'd0, 17'h0});
    // partial mask, ports take the token at different cycles
    v.push_back('{1'b0, 4'h5, 17'h000AA, 1'b1, 4'h0, 1'b1, 4'h0, 2'd0, 17'h0});
    v.push_back('{1'b0, 4'h5, 17'h00000, 1'b0, 4'h1, 1'b1, 4'h5, 2'd1, 17'h000AA});
    v.push_back('{1'b0, 4'h5, 17'h00000, 1'b0, 4'hA, 1'b1, 4'h4, 2'd1, 17'h000AA});
    v.push_back('{1'b0, 4'h5, 17'h00000, 1'b0, 4'h1, 1'b1, 4'h4, 2'd1, 17'h000AA});
    v.push_back('{1'b0, 4'h5, 17'h00000, 1'b0, 4'h4, 1'b1, 4'h4, 2'd1, 17'h000AA});
    v.push_back('{1'b0, 4'h5, 17'h00000, 1'b0, 4'h0, 1'b1, 4'h0, 2'd0, 17'h0});
    // fill with no consumer ready, third token held upstream
    v.push_back('{1'b0, 4'hF, 17'h00011, 1'b1, 4'h0, 1'b1, 4'h0, 2'd0, 17'h0});
    v.push_back('{1'b0, 4'hF, 17'h00022, 1'b1, 4'h0, 1'b1, 4'hF, 2'd1, 17'h00011});
    v.push_back('{1'b0, 4'hF, 17'h00033, 1'b1, 4'h0, 1'b0, 4'hF, 2'd2, 17'h00011});
    v.push_back('{1'b0, 4'hF, 17'h00033, 1'b1, 4'h0, 1'b0, 4'hF, 2'd2, 17'h00011});
    // port0 takes head, then flush with a push attempt
    v.push_back('{1'b0, 4'hF, 17'h00000, 1'b0, 4'h1, 1'b0, 4'hF, 2'd2, 17'h00011});
    v.push_back('{1'b1, 4'hF, 17'h00044, 1'b1, 4'h0, 1'b0, 4'hE, 2'd2, 17'h00011});
    v.push_back('{1'b0, 4'hF, 17'h00055, 1'b1, 4'h0, 1'b1, 4'h0, 2'd0, 17'h0});
    v.push_back('{1'b0, 4'hF, 17'h00000, 1'b0, 4'hF, 1'b1, 4'hF, 2'd1, 17'h00055});
    v.push_back('{1'b0, 4'hF, 17'h00000, 1'b0, 4'h0, 1'b1, 4'h0, 2'd0, 17'h0});
    // full FIFO refuses a push in the same cycle as a pop
    v.push_back('{1'b0, 4'hF, 17'h00066, 1'b1, 4'h0, 1'b1, 4'h0, 2'd0, 17'h0});
    v.push_back('{1'b0, 4'hF, 17'h00077, 1'b1, 4'h0, 1'b1, 4'hF, 2'd1, 17'h00066});
    v.push_back('{1'b0, 4'hF, 17'h00088, 1'b1, 4'hF, 1'b0, 4'hF, 2'd2, 17'h00066});
    v.push_back('{1'b0, 4'hF, 17'h00000, 1'b0, 4'hF, 1'b1, 4'hF, 2'd1, 17'h00077});
    v.push_back('{1'b0, 4'hF, 17'h00000, 1'b0, 4'h0, 1'b1, 4'h0, 2'd0, 17'h0});
    // empty mask discards every token
    v.push_back('{1'b0, 4'h0, 17'h00001, 1'b1, 4'hF, 1'b1, 4'h0, 2'd0, 17'h0});
    v.push_back('{1'b0, 4'h0, 17'h00002, 1'b1, 4'hF, 1'b1, 4'h0, 2'd1, 17'h0});
    v.push_back('{1'b0, 4'h0, 17'h00003, 1'b1, 4'hF, 1'b1, 4'h0, 2'd1, 17'h0});
    v.push_back('{1'b0, 4'h0, 17'h00004, 1'b1, 4'hF, 1'b1, 4'h0, 2'd1, 17'h0});
    v.push_back('{1'b0, 4'h0, 17'h00000, 1'b0, 4'hF, 1'b1, 4'h0, 2'd1, 17'h0});
    v.push_back('{1'b0, 4'h0, 17'h00000, 1'b0, 4'hF, 1'b1, 4'h0, 2'd0, 17'h0});

    @(negedge clk);
    #1 chk_out("reset", 1'b0, 4'h0, 2'd0, 17'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("release in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    #1 chk("first edge in_ready", 32'(in_ready), 32'd1);

    foreach (v[i]) begin
      @(negedge clk);
      flush = v[i].fl; en_mask = v[i].en; in_data = v[i].din;
      in_valid = v[i].iv; out_ready = v[i].ord;
      #1 chk_out($sformatf("r%0d", i), v[i].ir, v[i].ov, v[i].occ, v[i].dat);
    end

    // asynchronous reset between edges drops held tokens
    @(negedge clk);
    flush = 1'b0; en_mask = 4'hF; out_ready = 4'h0; in_valid = 1'b1; in_data = 17'h00012;
    @(negedge clk);
    in_data = 17'h00034;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("pre-reset occupancy", 32'(occupancy), 32'd2);
    #2 rst_n = 1'b0;
    #1 chk_out("async rst", 1'b0, 4'h0, 2'd0, 17'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_out("rst release", 1'b0, 4'h0, 2'd0, 17'h0);
    @(negedge clk);
    #1 chk_out("post rst", 1'b1, 4'h0, 2'd0, 17'h0);
    in_valid = 1'b1; in_data = 17'h0BEEF; out_ready = 4'hF;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk_out("fresh token", 1'b1, 4'hF, 2'd1, 17'h0BEEF);
    @(negedge clk);
    #1 chk_out("fresh drained", 1'b1, 4'h0, 2'd0, 17'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
